rtc_timebase: RTL and testbench

- Downstream consumer of the MCP7940N RTC wrapper's `tick` and `datetime` outputs.
- Keeps a free-running local BCD calendar clock plus a millisecond counter, advanced from `clk`.
- Re-synchronises the local clock to the RTC on every `tick`; flags when the RTC stops ticking.
- Gives the CPU a tear-free, byte-addressed snapshot of date/time and status.

---
 rtl/rtc_timebase.sv | 145 ++++++++++++++
 tb/tb_rtc_timebase.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timebase.sv
// Local BCD calendar clock + ms counter, re-synced to the RTC on every tick; CPU snapshot readout.
// Latency: tick loads time_bcd one cycle later; rd_data is combinational. No backpressure: all inputs are strobes.
module rtc_timebase #(
    parameter int CLK_HZ    = 25000000,
    parameter int TIMEOUT_S = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [55:0] datetime,
    input  logic        rd,
    input  logic [2:0]  addr,
    output logic [7:0]  rd_data,
    output logic [55:0] time_bcd,
    output logic [9:0]  ms_count,
    output logic        sec_pulse,
    output logic        valid,
    output logic        stale
);

    localparam int PRESC_MAX = CLK_HZ / 1000 - 1;
    localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_TC   = PW'(PRESC_MAX);
    localparam logic [7:0]    TO_MAX     = 8'(TIMEOUT_S);
    localparam logic [55:0]   RESET_TIME = 56'h00_01_01_01_00_00_00;

    logic [PW-1:0] presc;
    logic [7:0]    to_cnt;
    logic [55:0]   snap;
    logic [55:0]   next_time;
    logic [8:0]    ss_s, mi_s, hh_s, wd_s, dd_s, mm_s, yy_s;
    logic          ms_tc;

    // Returns {wrap, value}; anything at or beyond the field maximum wraps to its minimum.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] hi,
                                            input logic [7:0] lo);
        if (v >= hi)
            return {1'b1, lo};
        if (v[3:0] >= 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] month_last(input logic [7:0] mm, input logic [7:0] yy);
        logic leap;
        leap = (!yy[4] && (yy[3:0] == 4'd0 || yy[3:0] == 4'd4 || yy[3:0] == 4'd8)) ||
               ( yy[4] && (yy[3:0] == 4'd2 || yy[3:0] == 4'd6));
        case (mm)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    always_comb begin
        ss_s = bcd_step(time_bcd[7:0],   8'h59, 8'h00);
        mi_s = bcd_step(time_bcd[15:8],  8'h59, 8'h00);
        hh_s = bcd_step(time_bcd[23:16], 8'h23, 8'h00);
        wd_s = bcd_step(time_bcd[31:24], 8'h07, 8'h01);
        dd_s = bcd_step(time_bcd[39:32], month_last(time_bcd[47:40], time_bcd[55:48]), 8'h01);
        mm_s = bcd_step(time_bcd[47:40], 8'h12, 8'h01);
        yy_s = bcd_step(time_bcd[55:48], 8'h99, 8'h00);

        next_time       = time_bcd;
        next_time[7:0]  = ss_s[7:0];
        if (ss_s[8]) begin
            next_time[15:8] = mi_s[7:0];
            if (mi_s[8]) begin
                next_time[23:16] = hh_s[7:0];
                if (hh_s[8]) begin
                    next_time[31:24] = wd_s[7:0];
                    next_time[39:32] = dd_s[7:0];
                    if (dd_s[8]) begin
                        next_time[47:40] = mm_s[7:0];
                        if (mm_s[8])
                            next_time[55:48] = yy_s[7:0];
                    end
                end
            end
        end
    end

    assign ms_tc = (presc == PRESC_TC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            ms_count  <= '0;
            time_bcd  <= RESET_TIME;
            sec_pulse <= 1'b0;
            valid     <= 1'b0;
            stale     <= 1'b0;
            to_cnt    <= '0;
        end else begin
            sec_pulse <= 1'b0;
            // A tick overrides a coincident local rollover: load only.
            if (tick) begin
                presc     <= '0;
                ms_count  <= '0;
                time_bcd  <= datetime;
                sec_pulse <= 1'b1;
                valid     <= 1'b1;
                stale     <= 1'b0;
                to_cnt    <= '0;
            end else if (ms_tc) begin
                presc <= '0;
                if (ms_count == 10'd999) begin
                    ms_count  <= '0;
                    time_bcd  <= next_time;
                    sec_pulse <= 1'b1;
                    if (valid && to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt + 8'd1 == TO_MAX)
                            stale <= 1'b1;
                    end
                end else begin
                    ms_count <= ms_count + 10'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            snap <= RESET_TIME;
        else if (rd && addr == 3'd0)
            snap <= time_bcd;
    end

    always_comb begin
        case (addr)
            3'd0:    rd_data = snap[7:0];
            3'd1:    rd_data = snap[15:8];
            3'd2:    rd_data = snap[23:16];
            3'd3:    rd_data = snap[31:24];
            3'd4:    rd_data = snap[39:32];
            3'd5:    rd_data = snap[47:40];
            3'd6:    rd_data = snap[55:48];
            default: rd_data = {valid, stale, 6'b0};
        endcase
    end

endmodule

// File: tb/tb_rtc_timebase.sv
// Bench for rtc_timebase at CLK_HZ=4000: scoreboard queues for seconds events and CPU reads.
module tb_rtc_timebase;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [55:0] datetime;
    logic        rd;
    logic [2:0]  addr;
    logic [7:0]  rd_data;
    logic [55:0] time_bcd;
    logic [9:0]  ms_count;
    logic        sec_pulse;
    logic        valid;
    logic        stale;

    always #5 clk = ~clk;

    rtc_timebase #(.CLK_HZ(4000), .TIMEOUT_S(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .datetime  (datetime),
        .rd        (rd),
        .addr      (addr),
        .rd_data   (rd_data),
        .time_bcd  (time_bcd),
        .ms_count  (ms_count),
        .sec_pulse (sec_pulse),
        .valid     (valid),
        .stale     (stale)
    );

    typedef struct packed {
        logic [55:0] t;
        logic        v;
        logic        s;
    } pulse_t;

    pulse_t     pq[$];
    logic [7:0] rq[$];
    int         total = 0;
    int         bad   = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_sec(input logic [55:0] t, input logic s);
        pulse_t p;
        p.t = t;
        p.v = 1'b1;
        p.s = s;
        pq.push_back(p);
    endtask

    task automatic send_tick(input logic [55:0] dt);
        tick     = 1'b1;
        datetime = dt;
        expect_sec(dt, 1'b0);
        step();
        tick = 1'b0;
    endtask

    // Data is checked in the cycle after the strobe, with addr still held.
    task automatic do_read(input logic [2:0] a, input logic [7:0] exp_d);
        addr = a;
        rd   = 1'b1;
        rq.push_back(exp_d);
        step();
        rd = 1'b0;
        step();
    endtask

    // Monitor: pops expectations whenever the DUT presents a seconds event or read data.
    logic       rd_pend    = 1'b0;
    logic       prev_pulse = 1'b0;
    int         pulse_no   = 0;
    pulse_t     ep;
    logic [7:0] er;

    always @(negedge clk) begin
        if (rd_pend) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got %h, want nothing queued", rd_data);
            end else begin
                er = rq.pop_front();
                if (rd_data !== er) begin
                    bad++;
                    $display("FAIL rd addr=%0d: got %h, want %h", addr, rd_data, er);
                end
            end
        end
        rd_pend = rd;

        if (sec_pulse === 1'b1) begin
            pulse_no++;
            total++;
            if (pq.size() == 0) begin
                bad++;
                $display("FAIL sec_pulse#%0d unexpected: t=%h", pulse_no, time_bcd);
            end else begin
                ep = pq.pop_front();
                if (time_bcd !== ep.t || ms_count !== 10'd0 || valid !== ep.v ||
                    stale !== ep.s || prev_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL sec_pulse#%0d: got t=%h ms=%0d v=%b s=%b dbl=%b, want t=%h ms=0 v=%b s=%b dbl=0",
                             pulse_no, time_bcd, ms_count, valid, stale, prev_pulse, ep.t, ep.v, ep.s);
                end
            end
        end
        prev_pulse = sec_pulse;
    end

    logic [55:0] vin  [7];
    logic [55:0] vout [7];
    logic [7:0]  rst_bytes [8];

    initial begin
        reset    = 1'b0;
        tick     = 1'b0;
        datetime = '0;
        rd       = 1'b0;
        addr     = 3'd0;

        vin  = '{56'h23_02_28_07_23_59_59, 56'h99_12_31_05_23_59_59, 56'h24_04_30_02_23_59_59,
                 56'h00_02_28_01_23_59_59, 56'h24_01_15_01_09_59_59, 56'h24_01_15_01_10_19_75,
                 56'h24_04_31_02_23_59_59};
        vout = '{56'h23_03_01_01_00_00_00, 56'h00_01_01_06_00_00_00, 56'h24_05_01_03_00_00_00,
                 56'h00_02_29_02_00_00_00, 56'h24_01_15_01_10_00_00, 56'h24_01_15_01_10_20_00,
                 56'h24_05_01_03_00_00_00};
        rst_bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};

        // Reset values through the CPU port
        step(4);
        reset = 1'b1;
        step(2);
        for (int i = 0; i < 8; i++)
            do_read(3'(i), rst_bytes[i]);

        // Tick load, then leap-day advance
        send_tick(56'h24_02_28_03_23_59_59);
        expect_sec(56'h24_02_29_04_00_00_00, 1'b0);
        step(4000);
        step(2);

        // Calendar rollovers
        for (int i = 0; i < 7; i++) begin
            send_tick(vin[i]);
            expect_sec(vout[i], 1'b0);
            step(4000);
            step(2);
        end

        // Stale after three silent local seconds, cleared by the next tick
        send_tick(56'h24_06_15_06_12_00_00);
        expect_sec(56'h24_06_15_06_12_00_01, 1'b0);
        expect_sec(56'h24_06_15_06_12_00_02, 1'b0);
        expect_sec(56'h24_06_15_06_12_00_03, 1'b1);
        step(12000);
        step(2);
        do_read(3'd7, 8'hC0);
        send_tick(56'h24_06_15_06_12_30_00);
        step(2);
        do_read(3'd7, 8'h80);

        // Tick on the final prescaler cycle of a second: load wins
        send_tick(56'h24_07_04_04_08_30_09);
        step(3999);
        send_tick(56'h24_07_04_04_08_30_10);
        expect_sec(56'h24_07_04_04_08_30_11, 1'b0);
        step(4000);
        step(2);

        // Snapshot coherence across a minute rollover
        send_tick(56'h24_07_04_04_08_00_59);
        do_read(3'd0, 8'h59);
        expect_sec(56'h24_07_04_04_08_01_00, 1'b0);
        step(4000);
        do_read(3'd1, 8'h00);
        do_read(3'd0, 8'h00);
        do_read(3'd1, 8'h01);
        do_read(3'd2, 8'h08);
        do_read(3'd7, 8'h80);

        // Reset mid-operation, with a tick during reset that must be ignored
        send_tick(56'h24_12_25_03_10_20_30);
        do_read(3'd0, 8'h30);
        reset    = 1'b0;
        tick     = 1'b1;
        datetime = 56'h11_11_11_02_11_11_11;
        step(3);
        tick = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);
        for (int i = 7; i >= 0; i--)
            do_read(3'(i), rst_bytes[i]);

        step(5);
        total++;
        if (pq.size() != 0) begin
            bad++;
            $display("FAIL sec_pulse_missing: %0d seconds events still expected, want 0", pq.size());
        end
        total++;
        if (rq.size() != 0) begin
            bad++;
            $display("FAIL rd_missing: %0d reads still expected, want 0", rq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
